// File: rtl/ysyx_23060191_ifu_fetch.sv
// ysyx_23060191_ifu_fetch
//   Instruction fetch controller. It owns the architectural PC and issues one
//   read to the instruction memory. It waits MEM_LAT cycles, captures the
//   returned word, and presents {pc, inst} to decode over valid/ready.
//   Redirects from execute/writeback replace the PC and restart the fetch.
//
// Ports
//   clk            : clock, all state updates on the rising edge
//   rst_n          : synchronous active-low reset
//   mem_rd_en      : instruction memory read enable (high during FETCH)
//   mem_pc         : instruction memory address (always the internal PC)
//   mem_inst       : instruction word returned by memory
//   redirect_valid : one-cycle pulse, replace the PC
//   redirect_pc    : redirect target, bits [1:0] forced to zero
//   out_valid      : instruction available to decode
//   out_ready      : decode accepts the instruction this cycle
//   out_pc         : PC of the presented instruction
//   out_inst       : presented instruction
//
// MEM_LAT must lie in 1..8 so that MEM_LAT-1 fits the 3-bit latency counter.

module ysyx_23060191_ifu_fetch #(
   parameter int unsigned          CPU_WIDTH = 32,
   parameter logic [CPU_WIDTH-1:0] RESET_PC  = 32'h8000_0000,
   parameter int unsigned          MEM_LAT   = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic                 mem_rd_en,
   output logic [CPU_WIDTH-1:0] mem_pc,
   input  logic [CPU_WIDTH-1:0] mem_inst,
   input  logic                 redirect_valid,
   input  logic [CPU_WIDTH-1:0] redirect_pc,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CPU_WIDTH-1:0] out_pc,
   output logic [CPU_WIDTH-1:0] out_inst
);

   typedef enum logic [1:0] {StIdle, StFetch, StValid} state_e;

   // Counter value in the last FETCH cycle, where mem_inst is usable.
   localparam logic [2:0] LastCnt = 3'(MEM_LAT - 1);

   state_e               r_state;
   logic [CPU_WIDTH-1:0] r_pc;
   logic [2:0]           r_cnt;
   logic [CPU_WIDTH-1:0] r_out_pc;
   logic [CPU_WIDTH-1:0] r_out_inst;

   state_e               w_state;
   logic [CPU_WIDTH-1:0] w_pc;
   logic [2:0]           w_cnt;
   logic [CPU_WIDTH-1:0] w_out_pc;
   logic [CPU_WIDTH-1:0] w_out_inst;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= StIdle;
         r_pc       <= RESET_PC;
         r_cnt      <= 3'd0;
         r_out_pc   <= RESET_PC;
         r_out_inst <= '0;
      end else begin
         r_state    <= w_state;
         r_pc       <= w_pc;
         r_cnt      <= w_cnt;
         r_out_pc   <= w_out_pc;
         r_out_inst <= w_out_inst;
      end
   end

   always_comb begin
      w_state    = r_state;
      w_pc       = r_pc;
      w_cnt      = r_cnt;
      w_out_pc   = r_out_pc;
      w_out_inst = r_out_inst;

      if (redirect_valid) begin
         // Redirect wins over any in-progress fetch or handshake; a handshake
         // in this cycle still completes because decode sampled out_valid.
         w_pc    = {redirect_pc[CPU_WIDTH-1:2], 2'b00};
         w_cnt   = 3'd0;
         w_state = StFetch;
      end else begin
         unique case (r_state)
            StIdle: begin
               w_cnt   = 3'd0;
               w_state = StFetch;
            end
            StFetch: begin
               w_cnt = r_cnt + 3'd1;
               if (r_cnt == LastCnt) begin
                  w_out_inst = mem_inst;
                  w_out_pc   = r_pc;
                  w_state    = StValid;
               end
            end
            StValid: begin
               if (out_ready) begin
                  w_pc    = r_pc + CPU_WIDTH'(4);
                  w_cnt   = 3'd0;
                  w_state = StFetch;
               end
            end
            default: w_state = StIdle;
         endcase
      end
   end

   // All outputs come straight from registers.
   assign mem_rd_en = (r_state == StFetch);
   assign mem_pc    = r_pc;
   assign out_valid = (r_state == StValid);
   assign out_pc    = r_out_pc;
   assign out_inst  = r_out_inst;

endmodule

// File: tb/tb_ysyx_23060191_ifu_fetch.sv
// Bench for ysyx_23060191_ifu_fetch. Two instances (MEM_LAT=1 and MEM_LAT=3)
// share the control inputs; each has its own combinational memory and its
// own behavioural model that tracks "fetch cycles left" per instruction.

module tb_ysyx_23060191_ifu_fetch;

   localparam int NDut = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        out_ready = 1'b1;

   logic        mem_rd_en [NDut];
   logic [31:0] mem_pc    [NDut];
   logic [31:0] mem_inst  [NDut];
   logic        out_valid [NDut];
   logic [31:0] out_pc    [NDut];
   logic [31:0] out_inst  [NDut];

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
   endfunction

   for (genvar g = 0; g < NDut; g++) begin : g_dut
      assign mem_inst[g] = mem_word(mem_pc[g]);
      ysyx_23060191_ifu_fetch #(
         .CPU_WIDTH(32),
         .RESET_PC (32'h8000_0000),
         .MEM_LAT  ((g == 0) ? 1 : 3)
      ) u_dut (
         .clk           (clk),
         .rst_n         (rst_n),
         .mem_rd_en     (mem_rd_en[g]),
         .mem_pc        (mem_pc[g]),
         .mem_inst      (mem_inst[g]),
         .redirect_valid(redirect_valid),
         .redirect_pc   (redirect_pc),
         .out_valid     (out_valid[g]),
         .out_ready     (out_ready),
         .out_pc        (out_pc[g]),
         .out_inst      (out_inst[g])
      );
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural model: m_left = fetch cycles still to wait, 0 = presenting.
   int          lat    [NDut] = '{1, 3};
   bit          m_known[NDut];
   bit          m_idle [NDut];
   int          m_left [NDut];
   logic [31:0] m_pc   [NDut];
   logic [31:0] m_opc  [NDut];
   logic [31:0] m_oinst[NDut];

   function automatic bit m_valid(input int d);
      return !m_idle[d] && m_left[d] == 0;
   endfunction

   task automatic model_step(input int d);
      if (!rst_n) begin
         m_known[d] = 1'b1;
         m_idle[d]  = 1'b1;
         m_left[d]  = lat[d];
         m_pc[d]    = 32'h8000_0000;
         m_opc[d]   = 32'h8000_0000;
         m_oinst[d] = 32'h0;
      end else if (redirect_valid) begin
         m_idle[d] = 1'b0;
         m_pc[d]   = redirect_pc & 32'hFFFF_FFFC;
         m_left[d] = lat[d];
      end else if (m_idle[d]) begin
         m_idle[d] = 1'b0;
         m_left[d] = lat[d];
      end else if (m_left[d] > 0) begin
         if (m_left[d] == 1) begin
            m_opc[d]   = m_pc[d];
            m_oinst[d] = mem_word(m_pc[d]);
         end
         m_left[d]--;
      end else if (out_ready) begin
         m_pc[d]   = m_pc[d] + 32'd4;
         m_left[d] = lat[d];
      end
   endtask

   // Compare all outputs at the falling edge, then advance one clock.
   task automatic cycle();
      for (int d = 0; d < NDut; d++) begin
         if (m_known[d]) begin
            check_eq($sformatf("d%0d_mem_rd_en", d), 32'(mem_rd_en[d]),
                     32'(!m_idle[d] && m_left[d] > 0));
            check_eq($sformatf("d%0d_mem_pc", d), mem_pc[d], m_pc[d]);
            check_eq($sformatf("d%0d_out_valid", d), 32'(out_valid[d]), 32'(m_valid(d)));
            check_eq($sformatf("d%0d_out_pc", d), out_pc[d], m_opc[d]);
            check_eq($sformatf("d%0d_out_inst", d), out_inst[d], m_oinst[d]);
         end
      end
      @(posedge clk);
      for (int d = 0; d < NDut; d++) model_step(d);
      @(negedge clk);
   endtask

   // Run until the MEM_LAT=3 instance presents, bounded; returns cycles used.
   task automatic wait_valid1(input string tag, output int n);
      n = 0;
      while (!out_valid[1] && n < 20) begin
         cycle();
         n++;
      end
      if (!out_valid[1]) check_eq({tag, "_timeout"}, 32'(n), 32'(0));
   endtask

   initial begin
      int n;

      // Reset, then free-running fetch with no backpressure.
      rst_n = 1'b0;
      out_ready = 1'b1;
      cycle();
      cycle();
      rst_n = 1'b1;
      check_eq("rst_out_valid", 32'(out_valid[1]), 32'h0);
      check_eq("rst_mem_pc", mem_pc[0], 32'h8000_0000);
      repeat (12) cycle();

      // Backpressure: hold ready low while both instances sit in VALID.
      out_ready = 1'b0;
      repeat (8) cycle();
      check_eq("bp_mem_rd_en", 32'(mem_rd_en[1]), 32'h0);
      out_ready = 1'b1;
      repeat (4) cycle();

      // Redirect on the 2nd FETCH cycle of the MEM_LAT=3 instance.
      wait_valid1("pre_redir", n);
      cycle();
      cycle();
      redirect_valid = 1'b1;
      redirect_pc = 32'h8000_1002;
      cycle();
      redirect_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_eq("redir_mem_pc", mem_pc[1], 32'h8000_1000);
         cycle();
      end
      check_eq("redir_out_pc", out_pc[1], 32'h8000_1000);
      check_eq("redir_out_valid", 32'(out_valid[1]), 32'h1);

      // Redirect coincident with a handshake.
      out_ready = 1'b0;
      cycle();
      redirect_valid = 1'b1;
      redirect_pc = 32'h8000_0010;
      cycle();
      redirect_valid = 1'b0;
      wait_valid1("hs_a", n);
      check_eq("hs_cur_pc", out_pc[1], 32'h8000_0010);
      out_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h8000_0100;
      cycle();
      redirect_valid = 1'b0;
      wait_valid1("hs_b", n);
      check_eq("hs_next_pc", out_pc[1], 32'h8000_0100);

      // One-cycle reset mid-fetch; first output 4 cycles after release.
      cycle();
      cycle();
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      check_eq("midrst_mem_pc", mem_pc[1], 32'h8000_0000);
      wait_valid1("midrst", n);
      check_eq("midrst_latency", 32'(n), 32'd4);

      // PC wrap-around.
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      cycle();
      redirect_valid = 1'b0;
      wait_valid1("wrap_a", n);
      check_eq("wrap_first_pc", out_pc[1], 32'hFFFF_FFFC);
      cycle();
      check_eq("wrap_mem_pc", mem_pc[1], 32'h0000_0000);
      wait_valid1("wrap_b", n);
      check_eq("wrap_out_pc", out_pc[1], 32'h0000_0000);

      // Randomized traffic.
      for (int i = 0; i < 2000; i++) begin
         rst_n = ($urandom_range(63) != 0);
         redirect_valid = ($urandom_range(7) == 0);
         redirect_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                : $urandom();
         out_ready = $urandom_range(1) != 0;
         cycle();
      end
      rst_n = 1'b1;
      redirect_valid = 1'b0;
      repeat (4) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/ysyx_23060191_ifu_fetch.md
Name: ysyx_23060191_ifu_fetch

Overview:
- Fetch controller directly upstream of the instruction memory read port.
- Owns the architectural PC and drives the memory read enable and address. It waits a fixed, parameterised memory latency, then captures the returned instruction.
- Presents the captured {pc, inst} pair to the decode stage over a valid/ready handshake.
- Accepts redirects (jump, branch, trap) from the execute/writeback side.

Parameters:
- CPU_WIDTH, 32, datapath width for PC and instruction.
- RESET_PC, 32'h8000_0000, first fetch address after reset.
- MEM_LAT, 1, cycles from mem_rd_en assertion to a usable mem_inst. Legal range 1..8.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- mem_rd_en  out  1  read enable to the instruction memory.
- mem_pc  out  CPU_WIDTH  read address to the instruction memory.
- mem_inst  in  CPU_WIDTH  instruction returned by the memory.
- redirect_valid  in  1  one-cycle pulse: replace the PC.
- redirect_pc  in  CPU_WIDTH  new PC; bits [1:0] are ignored and treated as 0.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts the instruction this cycle.
- out_pc  out  CPU_WIDTH  PC of the presented instruction.
- out_inst  out  CPU_WIDTH  presented instruction.

Behaviour:
- State machine has three states: IDLE, FETCH, VALID. The latency counter cnt is 3 bits wide.
- Reset (rst_n=0 at a clock edge), from any state including mid-fetch:
  - state=IDLE, pc=RESET_PC, cnt=0.
  - out_valid=0, out_pc=RESET_PC, out_inst=0.
  - Any in-flight fetch is abandoned.
- IDLE:
  - mem_rd_en=0.
  - Next cycle goes to FETCH with cnt=0.
- FETCH:
  - mem_rd_en=1 and mem_pc=pc, both held stable for the whole FETCH period.
  - cnt increments each cycle.
  - In the cycle where cnt==MEM_LAT-1: out_inst<=mem_inst, out_pc<=pc, and the state goes to VALID.
  - FETCH therefore lasts exactly MEM_LAT cycles.
- VALID:
  - mem_rd_en=0, out_valid=1.
  - out_pc and out_inst are held stable until the handshake completes.
  - Handshake (out_valid and out_ready): pc<=pc+4, modulo 2^CPU_WIDTH (0xFFFF_FFFC wraps to 0x0000_0000). Then cnt<=0, state goes to FETCH, and out_valid drops the next cycle.
  - out_ready while not VALID is ignored.
- out_valid is registered: it equals 1 exactly when the state is VALID.
- Throughput is one instruction per MEM_LAT+1 cycles with no backpressure.
- First out_valid appears MEM_LAT+1 cycles after reset deassertion: one IDLE cycle plus MEM_LAT FETCH cycles.
- Redirect has priority over everything except reset. On redirect_valid=1 in any state:
  - pc<={redirect_pc[CPU_WIDTH-1:2],2'b00}, cnt<=0, state goes to FETCH, out_valid<=0.
  - A partially completed fetch is discarded; mem_inst is not captured that cycle.
- Redirect in the same cycle as a VALID handshake: the handshake counts as a completed transfer and decode owns that instruction. The next PC is the redirect target, not pc+4.
- Redirect in IDLE: the first fetch uses the redirect target.
- Back-to-back redirects: the last one wins. Each one restarts the full MEM_LAT fetch.
- mem_pc always equals the internal pc register, even while mem_rd_en=0.
- No combinational path from any input to any output.

Test Plan:
- Reset then run with MEM_LAT=1, out_ready=1 -> mem_pc sequence 0x80000000, 0x80000004, 0x80000008. out_valid pulses every 2nd cycle; out_inst equals the memory word at each out_pc.
- Backpressure: out_ready=0 for 5 cycles while VALID -> out_valid stays 1, out_pc/out_inst unchanged, mem_rd_en=0. out_ready=1 then advances the PC by 4.
- MEM_LAT=3, redirect_valid with redirect_pc=0x80001002 on the 2nd FETCH cycle -> old fetch is dropped. mem_pc becomes 0x80001000 for 3 cycles, then out_pc=0x80001000 is presented.
- Redirect to 0x80000100 in the same cycle as a handshake at out_pc=0x80000010 -> that transfer completes; the next out_pc=0x80000100, not 0x80000014.
- rst_n=0 for one cycle mid-FETCH (MEM_LAT=3, cnt=1) -> next cycle state=IDLE, out_valid=0, pc=0x80000000. The first output appears 4 cycles after release.
- Wrap-around: redirect to 0xFFFFFFFC, then accept -> next mem_pc=0x00000000 and out_pc=0x00000000 on the following fetch.
